// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dpram port-A arbiter.
// Pulled in by dpram_port_arbiter and rr_arb2.
package dpram_arb_pkg;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } pend_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin winner select.
// The pointer moves past the winner only on cycles where hold is low.
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    hold,
  output logic    win_vld,
  output req_id_t win_id
);

  req_id_t rr_ptr;

  always_comb begin
    win_vld = req0 | req1;
    win_id  = 1'b0;
    if (req0 && req1) win_id = rr_ptr;
    else if (req1)    win_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                   rr_ptr <= 1'b0;
    else if (win_vld && !hold) rr_ptr <= ~win_id;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of dpram port A between two requesters, with fixed 3-cycle read return.
// Optional DPRAM_ARB_ADDR_CHECK_EN adds an err pulse and suppresses out-of-range accesses.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
`ifdef DPRAM_ARB_ADDR_CHECK_EN
  ,
  output logic          err
`endif
);

  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_depth_chk
    $error("DEPTH does not fit in the AW-bit address space");
  end

  logic          win_vld;
  req_id_t       win_id;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          busy;
  logic          issue;
  logic          hold;
  logic          oor;
  logic [AW-1:0] addr_q;
  pend_t         pend_p0;
  pend_t         pend_p1;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .hold    (hold),
    .win_vld (win_vld),
    .win_id  (win_id)
  );

  assign win_we    = win_id ? we1    : we0;
  assign win_addr  = win_id ? addr1  : addr0;
  assign win_wdata = win_id ? wdata1 : wdata0;

  // A write freezes the RAM read pipeline, so it waits until no read is in flight.
  assign busy  = pend_p0.valid | pend_p1.valid;
  assign issue = win_vld & ~rst & ((win_we == READ) | ~busy);
  assign hold  = ~issue;

`ifdef DPRAM_ARB_ADDR_CHECK_EN
  assign oor = ({1'b0, win_addr} >= (AW+1)'(DEPTH));
  assign err = issue & oor;
`else
  assign oor = 1'b0;
`endif

  assign gnt0     = issue & ~win_id;
  assign gnt1     = issue &  win_id;
  assign ram_we   = issue & (win_we == WRITE) & ~oor;
  assign ram_addr = issue ? win_addr  : addr_q;
  assign ram_din  = issue ? win_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      pend_p0 <= '0;
      pend_p1 <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      if (issue) addr_q <= win_addr;
      // p0: read issued last cycle; p1: ram_dout valid now; then rvalid/rdata register
      pend_p0 <= {issue & (win_we == READ) & ~oor, win_id};
      pend_p1 <= pend_p0;
      rvalid0 <= pend_p1.valid & ~pend_p1.id;
      rvalid1 <= pend_p1.valid &  pend_p1.id;
      if (pend_p1.valid) rdata <= ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(ram_we && busy));
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter with a behavioural 2-stage-address dpram on port A.
// Build with DPRAM_ARB_ADDR_CHECK_EN defined to include the out-of-range access case.
module tb_dpram_port_arbiter;
  import dpram_arb_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
`ifdef DPRAM_ARB_ADDR_CHECK_EN
  logic          err;
`endif

  dpram_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
`ifdef DPRAM_ARB_ADDR_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: address pipelined twice, write freezes the pipeline.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra1 = '0, ra2 = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[IW-1:0]] <= ram_din;
    else begin
      ra1 <= ram_addr;
      ra2 <= ra1;
    end
  end
  assign ram_dout = mem[ra2[IW-1:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] shadow [DEPTH];
  int            last_rd = -100;
  logic          m_we, m_inr;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  exp_t          m_e;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (gnt0 || gnt1) begin
        m_we  = gnt1 ? we1 : we0;
        m_a   = gnt1 ? addr1 : addr0;
        m_d   = gnt1 ? wdata1 : wdata0;
`ifdef DPRAM_ARB_ADDR_CHECK_EN
        m_inr = (int'(m_a) < DEPTH);
`else
        m_inr = 1'b1;
`endif
        if (m_we == WRITE) begin
          if (m_inr) shadow[m_a[IW-1:0]] = m_d;
        end else if (m_inr) begin
          sbq.push_back('{id: gnt1, data: shadow[m_a[IW-1:0]], due: cyc + 3});
          last_rd = cyc;
        end
      end
      if (gnt0 && gnt1) check("dual_gnt", 32'(1), 32'(0));
      if (ram_we) check("we_while_pend", 32'((cyc - last_rd) > 2), 32'(1));
      if (rvalid0 || rvalid1) begin
        if (sbq.size() == 0) begin
          check("spurious_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
        end else begin
          m_e = sbq.pop_front();
          check("rv_id", 32'({rvalid1, rvalid0}), m_e.id ? 32'(2) : 32'(1));
          check("rv_data", 32'(rdata), 32'(m_e.data));
          check("rv_latency", 32'(cyc), 32'(m_e.due));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic access(input logic id, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    drive(id, 1'b1, w, a, d);
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) break;
      if (k >= 10) begin
        check("access_timeout", 32'(0), 32'(1));
        break;
      end
      step();
    end
    step();
    drive(id, 1'b0, READ, '0, '0);
  endtask

  task automatic wait_idle();
    repeat (6) step();
    @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", 32'({gnt0, gnt1, rvalid0, rvalid1, ram_we, rdata}), 32'(0));
      if (i < 9) step();
    end
    check("idle_ram_bus", 32'({ram_addr, ram_din}), 32'(0));

    // write then read on the same address
    step();
    drive(1'b0, 1'b1, WRITE, 8'd3, 8'hA5);
    @(negedge clk);
    check("wr_gnt0", 32'({gnt0, gnt1}), 32'(2));
    check("wr_ram_we", 32'(ram_we), 32'(1));
    check("wr_ram_addr", 32'(ram_addr), 32'(3));
    check("wr_ram_din", 32'(ram_din), 32'(8'hA5));
    step();
    drive(1'b0, 1'b0, READ, '0, '0);
    drive(1'b1, 1'b1, READ, 8'd3, '0);
    @(negedge clk);
    check("rd_gnt1", 32'({gnt0, gnt1}), 32'(1));
    check("rd_ram_we", 32'(ram_we), 32'(0));
    step();
    drive(1'b1, 1'b0, READ, '0, '0);
    @(negedge clk);
    check("idle_ram_addr_hold", 32'({ram_addr, ram_din}), 32'({8'd3, 8'd0}));
    wait_idle();

    // preload; alternate requesters so the pointer ends back at R0
    access(1'b0, WRITE, 8'd1, 8'h11);
    access(1'b1, WRITE, 8'd2, 8'h22);
    access(1'b0, WRITE, 8'd0, 8'h3C);
    access(1'b1, WRITE, 8'd4, 8'h44);

    // contention: both read every cycle
    step();
    drive(1'b0, 1'b1, READ, 8'd1, '0);
    drive(1'b1, 1'b1, READ, 8'd2, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("cont_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      step();
    end
    drive(1'b0, 1'b0, READ, '0, '0);
    drive(1'b1, 1'b0, READ, '0, '0);
    wait_idle();

    // write stall behind an in-flight read
    step();
    drive(1'b0, 1'b1, READ, 8'd0, '0);
    @(negedge clk);
    check("stall_rd_gnt0", 32'(gnt0), 32'(1));
    step();
    drive(1'b0, 1'b0, READ, '0, '0);
    drive(1'b1, 1'b1, WRITE, 8'd5, 8'h5A);
    @(negedge clk);
    check("stall_n1", 32'({gnt0, gnt1, ram_we}), 32'(0));
    step();
    @(negedge clk);
    check("stall_n2", 32'({gnt0, gnt1, ram_we}), 32'(0));
    step();
    @(negedge clk);
    check("stall_n3_gnt1", 32'({gnt0, gnt1}), 32'(1));
    check("stall_n3_we", 32'(ram_we), 32'(1));
    check("stall_n3_rvalid0", 32'(rvalid0), 32'(1));
    check("stall_n3_rdata", 32'(rdata), 32'(8'h3C));
    step();
    drive(1'b1, 1'b0, READ, '0, '0);
    wait_idle();
    access(1'b0, READ, 8'd5, '0);
    wait_idle();

    // reset while a read is in flight
    step();
    drive(1'b0, 1'b1, READ, 8'd1, '0);
    @(negedge clk);
    check("rst_rd_gnt0", 32'(gnt0), 32'(1));
    step();
    drive(1'b0, 1'b0, READ, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_n2_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
    step();
    @(negedge clk);
    check("rst_n3_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
    check("rst_n3_rdata", 32'(rdata), 32'(0));
    step();
    drive(1'b0, 1'b1, READ, 8'd1, '0);
    drive(1'b1, 1'b1, READ, 8'd2, '0);
    @(negedge clk);
    check("rst_ptr_first", 32'({gnt0, gnt1}), 32'(2));
    step();
    @(negedge clk);
    check("rst_ptr_second", 32'({gnt0, gnt1}), 32'(1));
    step();
    drive(1'b0, 1'b0, READ, '0, '0);
    drive(1'b1, 1'b0, READ, '0, '0);
    wait_idle();

`ifdef DPRAM_ARB_ADDR_CHECK_EN
    // out-of-range write: granted, flagged, not written
    step();
    drive(1'b0, 1'b1, WRITE, 8'h09, 8'hFF);
    @(negedge clk);
    check("oor_gnt0", 32'({gnt0, gnt1}), 32'(2));
    check("oor_err", 32'(err), 32'(1));
    check("oor_ram_we", 32'(ram_we), 32'(0));
    step();
    drive(1'b0, 1'b0, READ, '0, '0);
    @(negedge clk);
    check("oor_err_clear", 32'(err), 32'(0));
    access(1'b0, READ, 8'd1, '0);
    wait_idle();
`endif

    check("final_drain", 32'(sbq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
